// File: rtl/ahb_split_arbiter.sv
// Central AHB arbiter with SPLIT masking, locked sequences and a default master.
// Optional ARB_ROUND_ROBIN_EN selects rotating priority; otherwise fixed priority (master 0 highest).
module ahb_split_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int MW             = 1,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic                   hready,
    input  logic [1:0]             hresp,
    input  logic [NUM_MASTERS-1:0] hsplit,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic                   hmastlock
);

    typedef enum logic {ST_ARB, ST_LOCK} state_t;

    localparam logic [1:0]             HTRANS_IDLE    = 2'b00;
    localparam logic [1:0]             HRESP_RETRY    = 2'b10;
    localparam logic [1:0]             HRESP_SPLIT    = 2'b11;
    localparam logic [NUM_MASTERS-1:0] DEFAULT_ONEHOT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MW-1:0]          DEFAULT_IDX    = MW'(DEFAULT_MASTER);

    state_t                   state_reg, state_next;
    logic [NUM_MASTERS-1:0]   grant_reg, grant_next;
    logic [NUM_MASTERS-1:0]   mask_reg, mask_next;
    logic [NUM_MASTERS-1:0]   split_set, excl, eligible, winner_onehot;
    logic [MW-1:0]            master_reg, master_next;
    logic [MW-1:0]            owner, winner;
    logic                     mastlock_reg, mastlock_next;
    logic                     any_eligible, split_first, retry_first;

    assign split_first = !hready && (hresp == HRESP_SPLIT);
    assign retry_first = !hready && (hresp == HRESP_RETRY);

    // A master under SPLIT is excluded on the same edge it gets masked, unless its slave
    // releases it in that very cycle (release beats the new mask).
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_mask
            assign split_set[gi] = split_first && (master_reg == MW'(gi)) && (gi != DEFAULT_MASTER);
            assign mask_next[gi] = (mask_reg[gi] | split_set[gi]) & ~hsplit[gi];
            assign excl[gi]      = mask_reg[gi] | (split_set[gi] & ~hsplit[gi]);
        end
    endgenerate

    assign eligible      = hbusreq & ~excl;
    assign any_eligible  = |eligible;
    assign winner_onehot = NUM_MASTERS'(1) << winner;

    always_comb begin
        owner = DEFAULT_IDX;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_reg[MW'(i)]) owner = MW'(i);
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic [MW-1:0] rr_ptr_reg, rr_ptr_next;
    logic          arb_load;

    always_comb begin : p_winner
        int idx;
        idx    = 0;
        winner = DEFAULT_IDX;
        // Walk from lowest to highest priority so the highest-priority hit is written last.
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (eligible[MW'(idx)]) winner = MW'(idx);
        end
    end

    always_comb begin : p_rr_inc
        int nxt;
        nxt = int'(winner) + 1;
        if (nxt >= NUM_MASTERS) nxt = 0;
        rr_ptr_next = MW'(nxt);
    end

    assign arb_load = split_first || (hready && (state_reg == ST_ARB));

    always_ff @(posedge hclk) begin
        if (hreset) begin
            rr_ptr_reg <= '0;
        end else if (arb_load && any_eligible) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end
`else
    always_comb begin
        winner = DEFAULT_IDX;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (eligible[MW'(i)]) winner = MW'(i);
        end
    end
`endif

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        master_next   = master_reg;
        mastlock_next = mastlock_reg;
        if (split_first) begin
            grant_next = winner_onehot;
            state_next = ST_ARB;
        end else if (retry_first) begin
            state_next = ST_ARB;
        end else if (hready) begin
            if (state_reg == ST_ARB) begin
                grant_next = winner_onehot;
                if (any_eligible && hlock[winner]) state_next = ST_LOCK;
            end else if (!hlock[owner] && (htrans == HTRANS_IDLE)) begin
                state_next = ST_ARB;
            end
            master_next   = owner;
            mastlock_next = (state_reg == ST_LOCK) || (state_next == ST_LOCK);
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_reg    <= ST_ARB;
            grant_reg    <= DEFAULT_ONEHOT;
            master_reg   <= DEFAULT_IDX;
            mastlock_reg <= 1'b0;
            mask_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            master_reg   <= master_next;
            mastlock_reg <= mastlock_next;
            mask_reg     <= mask_next;
        end
    end

    assign hgrant    = grant_reg;
    assign hmaster   = master_reg;
    assign hmastlock = mastlock_reg;

endmodule
